// File: rtl/mem_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pkg
// Description : Shared defines for the MEM/WB pipeline register: register-bus
//               widths and the load-operation encodings carried from MEM.
//               Also provides a decoder that maps unknown encodings to NONE.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_pkg;

    localparam int c_reg_bus_w      = 32;  // RegBus width
    localparam int c_reg_addr_bus_w = 5;   // RegAddrBus width
    localparam int c_ldop_w         = 3;

    typedef enum logic [c_ldop_w-1:0] {
        LDOP_NONE = 3'd0,
        LDOP_LB   = 3'd1,
        LDOP_LBU  = 3'd2,
        LDOP_LH   = 3'd3,
        LDOP_LHU  = 3'd4,
        LDOP_LW   = 3'd5
    } ldop_e;

    // Encodings 6 and 7 are not defined loads; they behave as NONE.
    function automatic ldop_e ldop_decode(input logic [c_ldop_w-1:0] raw);
        if (raw > 3'd5) begin
            return LDOP_NONE;
        end
        return ldop_e'(raw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_if
// Description : MEM -> WB bundle. Carries the MEM-stage entry offer (valid/
//               ready handshake, GPR write, load info, HI/LO write) and the
//               WB-stage register-file and HI/LO write ports.
//   slave  : used by mem_wb (consumes mem_*_i, drives mem_ready_o and wb_*)
//   master : used by the MEM-stage side / test driver
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_if
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = c_reg_bus_w,
    parameter int ADDR_W = c_reg_addr_bus_w
) ();

    logic              mem_valid_i;
    logic              mem_ready_o;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_waddr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [2:0]        mem_ldop_i;
    logic [1:0]        mem_byteoff_i;
    logic              mem_whilo_i;
    logic [DATA_W-1:0] mem_hi_i;
    logic [DATA_W-1:0] mem_lo_i;

    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_waddr_o;
    logic [DATA_W-1:0] wb_wdata_o;
    logic              wb_whilo_o;
    logic [DATA_W-1:0] wb_hi_o;
    logic [DATA_W-1:0] wb_lo_o;

    modport slave (
        input  mem_valid_i, mem_we_i, mem_waddr_i, mem_wdata_i, mem_ldop_i,
               mem_byteoff_i, mem_whilo_i, mem_hi_i, mem_lo_i,
        output mem_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o, wb_whilo_o,
               wb_hi_o, wb_lo_o
    );

    modport master (
        output mem_valid_i, mem_we_i, mem_waddr_i, mem_wdata_i, mem_ldop_i,
               mem_byteoff_i, mem_whilo_i, mem_hi_i, mem_lo_i,
        input  mem_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o, wb_whilo_o,
               wb_hi_o, wb_lo_o
    );

endinterface
`default_nettype wire

// File: rtl/mem_wb_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational little-endian load alignment. Selects the byte
//               or halfword addressed by byteoff from the raw load word and
//               sign- or zero-extends it; LW / NONE / unknown pass through.
//   ldop    : load operation (3 bits)
//   byteoff : load address[1:0]
//   word    : raw load word / ALU result
//   aligned : value to write back
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = c_reg_bus_w
) (
    input  wire logic [2:0]        ldop,
    input  wire logic [1:0]        byteoff,
    input  wire logic [DATA_W-1:0] word,
    output logic      [DATA_W-1:0] aligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = word[{byteoff, 3'b000} +: 8];
    assign w_half = word[{byteoff[1], 4'b0000} +: 16];

    always_comb begin
        aligned = word;
        case (ldop_decode(ldop))
            LDOP_LB:  aligned = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LDOP_LBU: aligned = {{(DATA_W-8){1'b0}}, w_byte};
            LDOP_LH:  aligned = {{(DATA_W-16){w_half[15]}}, w_half};
            LDOP_LHU: aligned = {{(DATA_W-16){1'b0}}, w_half};
            default:  aligned = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb
// Description : MEM/WB pipeline register with one skid entry. Entries are
//               load-aligned on capture, appear on wb_* one cycle after
//               acceptance, and commit once per entry (WB write strobes are
//               masked while stall_i is high). flush_i drops everything and
//               wins over stall_i.
//   clk, rst  : clock, asynchronous active-high reset
//   stall_i   : WB hold, no commit while high
//   flush_i   : discard held and incoming entries
//   bus       : mem_wb_if.slave (MEM offer + WB write ports)
// Config      : define MEM_WB_HILO_EN to store and forward the HI/LO write;
//               otherwise wb_whilo_o / wb_hi_o / wb_lo_o are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = c_reg_bus_w,
    parameter int ADDR_W = c_reg_addr_bus_w
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic stall_i,
    input  wire logic flush_i,
    mem_wb_if.slave   bus
);

    logic [DATA_W-1:0] w_aligned;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .ldop    (bus.mem_ldop_i),
        .byteoff (bus.mem_byteoff_i),
        .word    (bus.mem_wdata_i),
        .aligned (w_aligned)
    );

    // Valid/ready state. r_ready always equals !r_skid_valid but is its own
    // flop so mem_ready_o has no path from stall_i.
    logic r_out_valid;
    logic r_skid_valid;
    logic r_ready;

    logic              r_out_we;
    logic [ADDR_W-1:0] r_out_waddr;
    logic [DATA_W-1:0] r_out_wdata;
    logic              r_skid_we;
    logic [ADDR_W-1:0] r_skid_waddr;
    logic [DATA_W-1:0] r_skid_wdata;

    logic w_accept;
    logic w_out_from_skid;
    logic w_out_from_in;
    logic w_skid_load;
    logic w_out_valid_nxt;
    logic w_skid_valid_nxt;

    assign w_accept        = bus.mem_valid_i & r_ready & ~flush_i;
    assign w_out_from_skid = ~flush_i & ~stall_i & r_skid_valid;
    assign w_out_from_in   = ~flush_i & ~stall_i & ~r_skid_valid & w_accept;
    // Incoming entry parks in skid while WB holds, or while skid drains to out.
    assign w_skid_load     = w_accept & (stall_i | r_skid_valid);

    assign w_out_valid_nxt  = flush_i ? 1'b0 :
                              stall_i ? r_out_valid :
                                        (r_skid_valid | w_accept);
    assign w_skid_valid_nxt = flush_i         ? 1'b0 :
                              w_skid_load     ? 1'b1 :
                              w_out_from_skid ? 1'b0 : r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_ready      <= ~w_skid_valid_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_we     <= 1'b0;
            r_out_waddr  <= '0;
            r_out_wdata  <= '0;
            r_skid_we    <= 1'b0;
            r_skid_waddr <= '0;
            r_skid_wdata <= '0;
        end else begin
            if (w_out_from_skid) begin
                r_out_we    <= r_skid_we;
                r_out_waddr <= r_skid_waddr;
                r_out_wdata <= r_skid_wdata;
            end else if (w_out_from_in) begin
                r_out_we    <= bus.mem_we_i;
                r_out_waddr <= bus.mem_waddr_i;
                r_out_wdata <= w_aligned;
            end
            if (w_skid_load) begin
                r_skid_we    <= bus.mem_we_i;
                r_skid_waddr <= bus.mem_waddr_i;
                r_skid_wdata <= w_aligned;
            end
        end
    end

    assign bus.mem_ready_o = r_ready;
    // Masking with !stall_i means a held entry strobes only on its last cycle.
    assign bus.wb_we_o     = r_out_valid & r_out_we & (r_out_waddr != '0) & ~stall_i;
    assign bus.wb_waddr_o  = r_out_waddr;
    assign bus.wb_wdata_o  = r_out_wdata;

`ifdef MEM_WB_HILO_EN
    logic              r_out_whilo;
    logic [DATA_W-1:0] r_out_hi;
    logic [DATA_W-1:0] r_out_lo;
    logic              r_skid_whilo;
    logic [DATA_W-1:0] r_skid_hi;
    logic [DATA_W-1:0] r_skid_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_whilo  <= 1'b0;
            r_out_hi     <= '0;
            r_out_lo     <= '0;
            r_skid_whilo <= 1'b0;
            r_skid_hi    <= '0;
            r_skid_lo    <= '0;
        end else begin
            if (w_out_from_skid) begin
                r_out_whilo <= r_skid_whilo;
                r_out_hi    <= r_skid_hi;
                r_out_lo    <= r_skid_lo;
            end else if (w_out_from_in) begin
                r_out_whilo <= bus.mem_whilo_i;
                r_out_hi    <= bus.mem_hi_i;
                r_out_lo    <= bus.mem_lo_i;
            end
            if (w_skid_load) begin
                r_skid_whilo <= bus.mem_whilo_i;
                r_skid_hi    <= bus.mem_hi_i;
                r_skid_lo    <= bus.mem_lo_i;
            end
        end
    end

    assign bus.wb_whilo_o = r_out_valid & r_out_whilo & ~stall_i;
    assign bus.wb_hi_o    = r_out_hi;
    assign bus.wb_lo_o    = r_out_lo;
`else
    // HI/LO inputs remain on the bundle but are not stored in this build.
    logic w_unused_hilo;
    assign w_unused_hilo  = ^{bus.mem_whilo_i, bus.mem_hi_i, bus.mem_lo_i};

    assign bus.wb_whilo_o = 1'b0;
    assign bus.wb_hi_o    = '0;
    assign bus.wb_lo_o    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb
// Description : Self-checking bench for mem_wb. Directed scenarios followed by
//               random traffic, checked against an in-order entry-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb;

    logic clk;
    logic rst;
    logic stall;
    logic flush;

    mem_wb_if bus ();

    mem_wb dut (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } ent_t;

    // Model: q holds entries in commit order; if out_v, q[0] is the entry on
    // the WB port and the rest are parked; otherwise every entry is parked.
    ent_t q[$];
    bit   out_v;

    int checks;
    int errors;

    logic        s_we;
    logic [31:0] s_wdata;
    logic        s_ready;
    logic [4:0]  commit_log[$];

    function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit model_ready();
        return q.size() == int'(out_v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic st);
        logic exp_we;
        logic exp_whilo;
        exp_we    = 1'b0;
        exp_whilo = 1'b0;
        check("mem_ready", bus.mem_ready_o, model_ready());
        if (out_v) begin
            exp_we    = q[0].we && (q[0].waddr != 5'd0) && !st;
            exp_whilo = q[0].whilo && !st;
            check("wb_waddr", bus.wb_waddr_o, q[0].waddr);
            check("wb_wdata", bus.wb_wdata_o, q[0].data);
`ifdef MEM_WB_HILO_EN
            check("wb_hi", bus.wb_hi_o, q[0].hi);
            check("wb_lo", bus.wb_lo_o, q[0].lo);
`endif
        end
        check("wb_we", bus.wb_we_o, exp_we);
`ifdef MEM_WB_HILO_EN
        check("wb_whilo", bus.wb_whilo_o, exp_whilo);
`else
        check("wb_whilo", bus.wb_whilo_o, 1'b0);
        check("wb_hi", bus.wb_hi_o, 32'd0);
        check("wb_lo", bus.wb_lo_o, 32'd0);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, bus.mem_ready_o, 1'b1);
        check({tag, "_we"}, bus.wb_we_o, 1'b0);
        check({tag, "_whilo"}, bus.wb_whilo_o, 1'b0);
        check({tag, "_waddr"}, bus.wb_waddr_o, 32'd0);
        check({tag, "_wdata"}, bus.wb_wdata_o, 32'd0);
        check({tag, "_hi"}, bus.wb_hi_o, 32'd0);
        check({tag, "_lo"}, bus.wb_lo_o, 32'd0);
    endtask

    task automatic model_update(input logic st, input logic fl, input bit acc, input ent_t e);
        if (fl) begin
            q.delete();
            out_v = 1'b0;
        end else if (!st) begin
            if (out_v) void'(q.pop_front());
            if (q.size() > 0) begin
                out_v = 1'b1;
                if (acc) q.push_back(e);
            end else if (acc) begin
                q.push_back(e);
                out_v = 1'b1;
            end else begin
                out_v = 1'b0;
            end
        end else if (acc) begin
            q.push_back(e);
        end
    endtask

    // One clock cycle: drive at negedge, check just after, model at posedge.
    task automatic cyc(input logic st, input logic fl, input logic v, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic [2:0] op,
                       input logic [1:0] off, input logic wh, input logic [31:0] hi,
                       input logic [31:0] lo);
        ent_t e;
        bit   acc;
        @(negedge clk);
        stall             = st;
        flush             = fl;
        bus.mem_valid_i   = v;
        bus.mem_we_i      = we;
        bus.mem_waddr_i   = wa;
        bus.mem_wdata_i   = wd;
        bus.mem_ldop_i    = op;
        bus.mem_byteoff_i = off;
        bus.mem_whilo_i   = wh;
        bus.mem_hi_i      = hi;
        bus.mem_lo_i      = lo;
        #1;
        check_outputs(st);
        s_we    = bus.wb_we_o;
        s_wdata = bus.wb_wdata_o;
        s_ready = bus.mem_ready_o;
        if (s_we) commit_log.push_back(bus.wb_waddr_o);
        acc     = v && model_ready();
        e.we    = we;
        e.waddr = wa;
        e.data  = ref_align(op, off, wd);
        e.whilo = wh;
        e.hi    = hi;
        e.lo    = lo;
        @(posedge clk);
        model_update(st, fl, acc, e);
    endtask

    task automatic offer(input logic st, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [2:0] op, input logic [1:0] off);
        cyc(st, 1'b0, 1'b1, we, wa, wd, op, off, 1'b1, $urandom, $urandom);
    endtask

    task automatic idle(input logic st);
        cyc(st, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0, 32'd0);
    endtask

    // Assert rst between clock edges, check outputs react without an edge.
    task automatic mid_reset(input string tag);
        bus.mem_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state(tag);
        q.delete();
        out_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        out_v  = 1'b0;
        rst    = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        bus.mem_valid_i   = 1'b0;
        bus.mem_we_i      = 1'b0;
        bus.mem_waddr_i   = '0;
        bus.mem_wdata_i   = '0;
        bus.mem_ldop_i    = '0;
        bus.mem_byteoff_i = '0;
        bus.mem_whilo_i   = 1'b0;
        bus.mem_hi_i      = '0;
        bus.mem_lo_i      = '0;

        // Reset state, during and after reset
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("rst_during");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("rst_after");

        // LB sign-extension, one-cycle latency
        offer(1'b0, 1'b1, 5'd4, 32'h80FF_FF00, 3'd1, 2'd3);
        idle(1'b0);
        check("lb_we", s_we, 1'b1);
        check("lb_wdata", s_wdata, 32'hFFFF_FF80);

        // LHU upper halfword
        offer(1'b0, 1'b1, 5'd7, 32'h8001_1234, 3'd4, 2'd2);
        idle(1'b0);
        check("lhu_wdata", s_wdata, 32'h0000_8001);

        // Write to r0 never strobes
        offer(1'b0, 1'b1, 5'd0, 32'h1234_5678, 3'd5, 2'd0);
        idle(1'b0);
        check("r0_we", s_we, 1'b0);

        // Stall for 3 cycles with entries offered
        commit_log.delete();
        offer(1'b0, 1'b1, 5'd10, 32'hAAAA_0001, 3'd0, 2'd0);
        offer(1'b1, 1'b1, 5'd11, 32'hAAAA_0002, 3'd0, 2'd0);
        check("stall_2nd_ready", s_ready, 1'b1);
        offer(1'b1, 1'b1, 5'd12, 32'hAAAA_0003, 3'd0, 2'd0);
        check("stall_3rd_ready", s_ready, 1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        check("stall_commits", commit_log.size(), 32'd2);
        if (commit_log.size() == 2) begin
            check("stall_order0", commit_log[0], 5'd10);
            check("stall_order1", commit_log[1], 5'd11);
        end

        // Flush with stall while both slots are full
        offer(1'b0, 1'b1, 5'd13, 32'h0BAD_0001, 3'd0, 2'd0);
        offer(1'b1, 1'b1, 5'd14, 32'h0BAD_0002, 3'd0, 2'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd15, 32'h0BAD_0003, 3'd0, 2'd0, 1'b1, 32'd1, 32'd2);
        idle(1'b0);
        check("flush_we", s_we, 1'b0);
        check("flush_ready", s_ready, 1'b1);

        // Asynchronous reset while out holds a committing entry
        offer(1'b0, 1'b1, 5'd9, 32'h5555_AAAA, 3'd5, 2'd0);
        #2;
        check("pre_rst_we", bus.wb_we_o, 1'b1);
        mid_reset("async_rst");

        // Reset while stalled with both slots full discards everything
        offer(1'b0, 1'b1, 5'd20, 32'h1, 3'd0, 2'd0);
        offer(1'b1, 1'b1, 5'd21, 32'h2, 3'd0, 2'd0);
        mid_reset("stall_rst");
        commit_log.delete();
        idle(1'b0);
        idle(1'b0);
        check("stall_rst_commits", commit_log.size(), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5),
                ($urandom_range(0, 99) < 70), 1'($urandom),
                ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom),
                $urandom, 3'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the register/data width.
REQ-002 SHALL have parameter ADDR_W, default 5, the register address width.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port stall_i, input, 1, WB-stage hold; no commit while high.
REQ-006 SHALL have port flush_i, input, 1, discard all held and incoming entries.
REQ-007 SHALL have port mem_valid_i, input, 1, MEM entry offered.
REQ-008 SHALL have port mem_ready_o, output, 1, entry accepted when valid&ready.
REQ-009 SHALL have port mem_we_i, input, 1, entry writes the GPR.
REQ-010 SHALL have port mem_waddr_i, input, ADDR_W, destination GPR.
REQ-011 SHALL have port mem_wdata_i, input, DATA_W, ALU result or raw load word.
REQ-012 SHALL have port mem_ldop_i, input, 3, NONE/LB/LBU/LH/LHU/LW.
REQ-013 SHALL have port mem_byteoff_i, input, 2, load address[1:0].
REQ-014 SHALL have ports mem_whilo_i (1), mem_hi_i (DATA_W) and mem_lo_i (DATA_W), all inputs, the HI/LO write.
REQ-015 SHALL have ports wb_we_o (1), wb_waddr_o (ADDR_W) and wb_wdata_o (DATA_W), all outputs, the register-file write port.
REQ-016 SHALL have ports wb_whilo_o (1), wb_hi_o (DATA_W) and wb_lo_o (DATA_W), all outputs, the HI/LO write port.

Function
REQ-017 SHALL hold an output register (out) and one skid entry (skid), each with its own valid bit.
REQ-018 SHALL drive mem_ready_o = !skid_valid, taken from a flop with no combinational path from stall_i.
REQ-019 SHALL give one-cycle latency: an entry accepted at edge N appears on wb_* after edge N when stall_i=0.
REQ-020 SHALL, on stall_i=0, load out from skid if skid_valid (clearing skid_valid, incoming entry goes to skid), else from the incoming entry, else clear out_valid.
REQ-021 SHALL, on stall_i=1, hold out; an accepted incoming entry goes to skid.
REQ-022 SHALL assert wb_we_o = out_valid & out_we & (out_waddr != 0) & !stall_i, so each entry commits exactly once.
REQ-023 SHALL assert wb_whilo_o = out_valid & out_whilo & !stall_i.
REQ-024 SHALL perform load alignment before capture (little-endian, byte = wdata[8*off+:8]).
- LB/LBU: sign- or zero-extend the selected byte.
- LH/LHU: take the halfword at byteoff[1], sign- or zero-extended.
- LW and NONE: pass wdata unchanged.
REQ-025 SHALL, on flush_i=1, clear out_valid and skid_valid and drop any incoming entry; flush_i has priority over stall_i.
REQ-026 SHALL store unknown ldop encodings as NONE.

Reset
REQ-027 SHALL, on rst=1, clear out_valid and skid_valid immediately and zero all held data.
REQ-028 SHALL, during and after reset, drive wb_we_o=0, wb_whilo_o=0, wb_waddr_o=0, wb_wdata_o=0, wb_hi_o=0, wb_lo_o=0 and mem_ready_o=1.
REQ-029 SHALL discard all entries when reset is asserted mid-stall.

Configuration
REQ-030 SHALL, with macro MEM_WB_HILO_EN defined, register and forward mem_whilo_i, mem_hi_i and mem_lo_i per REQ-023.
REQ-031 SHALL, without MEM_WB_HILO_EN, keep the HI/LO ports, remove the HI/LO storage, and tie wb_whilo_o, wb_hi_o and wb_lo_o to 0.

Structure
REQ-032 SHALL take the RegBus and RegAddrBus widths and the ldop encodings (LDOP_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5) from the shared defines file.
REQ-033 SHALL implement alignment in a combinational sub-module load_align (inputs: ldop, byteoff, word; output: aligned data).

Verification
REQ-034 Bench SHALL show that LB, off=3, wdata=0x80FF_FF00, waddr=4, we=1 gives wb_wdata_o=0xFFFF_FF80 and wb_we_o=1 one cycle later.
REQ-035 Bench SHALL show that LHU, off=2, wdata=0x8001_1234 gives wb_wdata_o=0x0000_8001.
REQ-036 Bench SHALL show that with stall_i=1 for 3 cycles and two entries offered, the 2nd is accepted into skid, the 3rd sees mem_ready_o=0, and after release both commit in order with wb_we_o high exactly once each.
REQ-037 Bench SHALL show that a write to waddr=0 with we=1 gives wb_we_o=0.
REQ-038 Bench SHALL show that flush_i=1 together with stall_i=1 while out and skid are full gives no commit next cycle and mem_ready_o=1.
REQ-039 Bench SHALL show that asserting rst between clock edges while out_valid=1 drops wb_we_o to 0 without waiting for a clock edge.
